// File: rtl/mm_tile_issue_ctrl.sv
// Tile-by-tile command sequencer driving the iram/wram control buffers of the MXU.
// Optional RUN-state watchdog is enabled by defining MM_TILE_TIMEOUT_EN.
module mm_tile_issue_ctrl #(
  parameter int unsigned DRAIN_CYC   = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [3:0]  cmd_row_len,
  input  logic [3:0]  cmd_col_len,
  input  logic [3:0]  cmd_tiles,
  input  logic [11:0] cmd_iram_addr,
  input  logic [11:0] cmd_wram_addr,
  input  logic [11:0] cmd_iram_stride,
  input  logic [11:0] cmd_wram_stride,
  output logic        buff_ctrl_start,
  output logic        buff_ctrl_vld,
  output logic [3:0]  buff_ctrl_row_len,
  output logic [3:0]  buff_ctrl_col_len,
  output logic [11:0] buff_iram_start_addr,
  output logic [11:0] buff_wram_start_addr,
  input  logic        iram_mxu_end,
  input  logic        wram_mxu_end,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (DRAIN_CYC < 1 || DRAIN_CYC > 63 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 1023) begin : g_param_check
    $error("mm_tile_issue_ctrl: DRAIN_CYC or TIMEOUT_CYC out of range");
  end

  localparam logic [5:0] DRAIN_LAST = 6'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_len_q, row_len_d;
  logic [3:0]  col_len_q, col_len_d;
  logic [3:0]  tiles_q, tiles_d;
  logic [3:0]  tile_cnt_q, tile_cnt_d;
  logic [11:0] iram_addr_q, iram_addr_d;
  logic [11:0] wram_addr_q, wram_addr_d;
  logic [11:0] iram_stride_q, iram_stride_d;
  logic [11:0] wram_stride_q, wram_stride_d;
  logic        iram_seen_q, iram_seen_d;
  logic        wram_seen_q, wram_seen_d;
  logic [5:0]  drain_cnt_q, drain_cnt_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        busy_q, busy_d;
  logic        start_q, start_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic        both_end;

`ifdef MM_TILE_TIMEOUT_EN
  localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT_CYC - 1);
  logic [9:0] wdog_q, wdog_d;
  logic       abort_q, abort_d;
  logic       err_q, err_d;
`endif

  // A pulse arriving in the current cycle counts alongside the sticky flags.
  assign both_end = (iram_seen_q | iram_mxu_end) & (wram_seen_q | wram_mxu_end);

  always_comb begin
    // NOTE: every _d takes its held value first so no path through the case infers a latch.
    state_d       = state_q;
    row_len_d     = row_len_q;
    col_len_d     = col_len_q;
    tiles_d       = tiles_q;
    tile_cnt_d    = tile_cnt_q;
    iram_addr_d   = iram_addr_q;
    wram_addr_d   = wram_addr_q;
    iram_stride_d = iram_stride_q;
    wram_stride_d = wram_stride_q;
    iram_seen_d   = iram_seen_q;
    wram_seen_d   = wram_seen_q;
    drain_cnt_d   = drain_cnt_q;
`ifdef MM_TILE_TIMEOUT_EN
    wdog_d        = wdog_q;
    abort_d       = abort_q;
    err_d         = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (cmd_vld) begin
          row_len_d     = cmd_row_len;
          col_len_d     = cmd_col_len;
          tiles_d       = cmd_tiles;
          tile_cnt_d    = '0;
          iram_addr_d   = cmd_iram_addr;
          wram_addr_d   = cmd_wram_addr;
          iram_stride_d = cmd_iram_stride;
          wram_stride_d = cmd_wram_stride;
          state_d       = S_START;
        end
      end
      S_START: begin
        iram_seen_d = 1'b0;
        wram_seen_d = 1'b0;
`ifdef MM_TILE_TIMEOUT_EN
        wdog_d      = '0;
`endif
        state_d     = S_RUN;
      end
      S_RUN: begin
        iram_seen_d = iram_seen_q | iram_mxu_end;
        wram_seen_d = wram_seen_q | wram_mxu_end;
        if (both_end) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end
`ifdef MM_TILE_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 10'd1;
        end
`endif
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          if (tile_cnt_q == tiles_q) begin
            state_d = S_DONE;
          end else begin
            tile_cnt_d  = tile_cnt_q + 4'd1;
            iram_addr_d = iram_addr_q + iram_stride_q;
            wram_addr_d = wram_addr_q + wram_stride_q;
            state_d     = S_START;
          end
        end else begin
          drain_cnt_d = drain_cnt_q + 6'd1;
        end
      end
      S_DONE: begin
`ifdef MM_TILE_TIMEOUT_EN
        // After a watchdog abort, DONE is held one extra cycle so done trails err.
        if (abort_q) abort_d = 1'b0;
        else         state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    cmd_rdy_d = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    start_d   = (state_d == S_START);
    vld_d     = (state_d == S_START) || (state_d == S_RUN);
`ifdef MM_TILE_TIMEOUT_EN
    done_d    = (state_d == S_DONE) && !abort_d;
`else
    done_d    = (state_d == S_DONE);
`endif
  end

  // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_len_q     <= '0;
      col_len_q     <= '0;
      tiles_q       <= '0;
      tile_cnt_q    <= '0;
      iram_addr_q   <= '0;
      wram_addr_q   <= '0;
      iram_stride_q <= '0;
      wram_stride_q <= '0;
      iram_seen_q   <= 1'b0;
      wram_seen_q   <= 1'b0;
      drain_cnt_q   <= '0;
      cmd_rdy_q     <= 1'b1;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
      vld_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_len_q     <= row_len_d;
      col_len_q     <= col_len_d;
      tiles_q       <= tiles_d;
      tile_cnt_q    <= tile_cnt_d;
      iram_addr_q   <= iram_addr_d;
      wram_addr_q   <= wram_addr_d;
      iram_stride_q <= iram_stride_d;
      wram_stride_q <= wram_stride_d;
      iram_seen_q   <= iram_seen_d;
      wram_seen_q   <= wram_seen_d;
      drain_cnt_q   <= drain_cnt_d;
      cmd_rdy_q     <= cmd_rdy_d;
      busy_q        <= busy_d;
      start_q       <= start_d;
      vld_q         <= vld_d;
      done_q        <= done_d;
    end
  end

`ifdef MM_TILE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd_rdy              = cmd_rdy_q;
  assign busy                 = busy_q;
  assign buff_ctrl_start      = start_q;
  assign buff_ctrl_vld        = vld_q;
  assign done                 = done_q;
  assign buff_ctrl_row_len    = row_len_q;
  assign buff_ctrl_col_len    = col_len_q;
  assign buff_iram_start_addr = iram_addr_q;
  assign buff_wram_start_addr = wram_addr_q;

endmodule
